paralelo_serial_tx: RTL
=======================

PARALELO_SERIAL_TX -- requirements
Module: paralelo_serial_tx

Interface
REQ-001 SHALL have parameter TRAIN_COUNT, default 4: number of comma bytes sent after reset before data is accepted.
REQ-002 SHALL have parameter COMMA, default 8'hBC: idle/training byte.
REQ-003 SHALL have port clk_32f  input  1: single clock, one serial bit per cycle.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset, sampled on posedge clk_32f.
REQ-005 SHALL have port data_in  input  8: parallel byte to transmit.
REQ-006 SHALL have port valid_in  input  1: data_in holds a byte to send.
REQ-007 SHALL have port ready_out  output  1: block accepts data_in this cycle.
REQ-008 SHALL have port data_out  output  1: serial line, LSB first.
REQ-009 SHALL have port frame_start  output  1: high while data_out carries bit 0 of a byte.
REQ-010 SHALL have port tx_active  output  1: high once training is complete.
REQ-011 SHALL have port data_bytes  output  16: count of non-comma-slot data bytes started on the line.

Function
REQ-012 SHALL hold a 3-bit bit counter, incrementing every cycle and wrapping 7->0; each byte occupies exactly 8 cycles.
REQ-013 SHALL drive data_out directly from bit 0 of an 8-bit shift register, with no combinational logic after the flop; the shift register shifts right every cycle except at load.
REQ-014 SHALL load the shift register on the edge where the bit counter is 7, so a new byte's bit 0 appears while the counter is 0.
REQ-015 SHALL use a two-state FSM: TRAIN and RUN.
REQ-016 In TRAIN, SHALL load COMMA at every byte boundary and count completed comma bytes; on the boundary that completes comma number TRAIN_COUNT, SHALL move to RUN.
REQ-017 In RUN, at each byte boundary, SHALL load the holding register contents if it is full and clear it; otherwise SHALL load COMMA.
REQ-018 SHALL provide a one-entry holding register; ready_out = RUN and holding register empty.
REQ-019 SHALL accept a byte on an edge where valid_in and ready_out are both high.
REQ-020 SHALL not bypass the holding register: a byte accepted on the boundary edge is loaded at the next boundary, so the boundary being serviced sends COMMA.
REQ-021 Latency: a byte accepted at edge t SHALL start on data_out at the first boundary after t, within 1 to 8 cycles.
REQ-022 SHALL transmit data_in == COMMA unchanged and SHALL count it in data_bytes.
REQ-023 SHALL ignore valid_in while ready_out is low, with no capture and no error.
REQ-024 data_bytes SHALL increment by 1 at each boundary that loads from the holding register, and SHALL wrap from 16'hFFFF to 0.
REQ-025 tx_active SHALL be high exactly when the FSM is in RUN.
REQ-026 frame_start SHALL be high exactly when the bit counter is 0.

Reset
REQ-027 While reset is high, SHALL set: FSM = TRAIN, bit counter = 0, training counter = 0, shift register = COMMA, holding register empty, data_bytes = 0.
REQ-028 Resulting reset output values SHALL be: data_out = 0, frame_start = 1, ready_out = 0, tx_active = 0.
REQ-029 Reset mid-byte SHALL abort the byte in flight, discard the holding register, and restart training.
REQ-030 On the first cycle after reset deasserts, data_out SHALL carry COMMA bit 1; COMMA bit 0 is shown during the final reset cycle.

Structure
REQ-031 SHALL place COMMA's default value, the FSM state encoding, and the bit-counter width in the shared project package, which the matching receiver also uses.
REQ-032 SHALL split the design into two parts:
- a sub-module tx_shifter (8-bit load/shift register plus bit counter);
- FSM, holding register and counters in the top module.

Verification
REQ-033 Reset, then valid_in=0 for 64 cycles -> line carries 8 back-to-back 0xBC bytes, LSB first; ready_out rises at the boundary after the 4th comma.
REQ-034 After training, offer 8'hA5 with valid_in held -> accepted in 1 cycle; next byte slot carries 1,0,1,0,0,1,0,1; data_bytes = 1.
REQ-035 Stream 8'h01..8'h10 with valid_in held high -> ready_out shows one accept per 8 cycles; bytes appear in order with no comma between them; data_bytes = 16.
REQ-036 Offer a byte exactly on the bit-counter-7 edge -> that slot sends 0xBC and the byte follows in the next slot.
REQ-037 Assert reset at bit 3 of a data byte with the holding register full -> the held byte is never sent, 4 commas follow, and data_bytes = 0.
REQ-038 Preload data_bytes with 16'hFFFF via a long stream, send one more byte -> data_bytes = 0; send data 8'hBC -> it is counted.

Source files
------------

// File: rtl/paralelo_serial_tx_pkg.sv
// rtl/paralelo_serial_tx_pkg.sv - shared constants for the paralelo/serial link (tx and rx)
package paralelo_serial_tx_pkg;

    localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

    localparam int BIT_CNT_W = 3;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = '1;

    localparam logic [0:0] ST_TRAIN = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/paralelo_serial_tx_shifter.sv
// rtl/paralelo_serial_tx_shifter.sv - byte shift register and bit counter, LSB first
module tx_shifter
    import paralelo_serial_tx_pkg::*;
#(
    parameter logic [7:0] RESET_BYTE = COMMA_DEFAULT
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    input  logic [7:0]           next_byte,
    output logic                 serial_bit,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 boundary
);

    logic [7:0] shift_reg;

    // Loading on the last bit keeps bit 0 of the next byte aligned with bit_cnt == 0.
    assign boundary   = (bit_cnt == BIT_CNT_LAST);
    assign serial_bit = shift_reg[0];

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            shift_reg <= RESET_BYTE;
            bit_cnt   <= '0;
        end else begin
            bit_cnt <= bit_cnt + 1'b1;
            if (boundary) begin
                shift_reg <= next_byte;
            end else begin
                shift_reg <= {1'b0, shift_reg[7:1]};
            end
        end
    end

endmodule

// File: rtl/paralelo_serial_tx.sv
// rtl/paralelo_serial_tx.sv - parallel to serial transmitter with comma training
module paralelo_serial_tx
    import paralelo_serial_tx_pkg::*;
#(
    parameter int         TRAIN_COUNT = 4,
    parameter logic [7:0] COMMA       = COMMA_DEFAULT
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        data_out,
    output logic        frame_start,
    output logic        tx_active,
    output logic [15:0] data_bytes
);

    localparam int TRAIN_W = (TRAIN_COUNT > 1) ? $clog2(TRAIN_COUNT) : 1;
    localparam logic [TRAIN_W-1:0] TRAIN_LAST = TRAIN_W'(TRAIN_COUNT - 1);

    logic [0:0]           state;
    logic [TRAIN_W-1:0]   train_cnt;
    logic [7:0]           hold_data;
    logic                 hold_full;
    logic [7:0]           next_byte;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 boundary;

    assign ready_out   = (state == ST_RUN) && !hold_full;
    assign tx_active   = (state == ST_RUN);
    assign frame_start = (bit_cnt == '0);
    assign next_byte   = ((state == ST_RUN) && hold_full) ? hold_data : COMMA;

    tx_shifter #(
        .RESET_BYTE (COMMA)
    ) u_shifter (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .next_byte  (next_byte),
        .serial_bit (data_out),
        .bit_cnt    (bit_cnt),
        .boundary   (boundary)
    );

    // A byte accepted on a boundary edge is only captured here; the shifter
    // takes COMMA on that same edge because hold_full was still low.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state      <= ST_TRAIN;
            train_cnt  <= '0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            data_bytes <= '0;
        end else begin
            if (boundary) begin
                if (state == ST_TRAIN) begin
                    train_cnt <= train_cnt + 1'b1;
                    if (train_cnt == TRAIN_LAST) begin
                        state <= ST_RUN;
                    end
                end else if (hold_full) begin
                    hold_full  <= 1'b0;
                    data_bytes <= data_bytes + 16'd1;
                end
            end
            if (valid_in && ready_out) begin
                hold_data <= data_in;
                hold_full <= 1'b1;
            end
        end
    end

endmodule
